// File: rtl/cpu_pkg.sv
// ---------------------------------------------------------------------------
// cpu_pkg
// Shared encodings for the 16-bit processor core: instruction classes (op1),
// immediate/branch sub-ops (op2), ALU opcodes, branch condition codes,
// write-back source select, sequencer state and the decoded control bundle.
// ---------------------------------------------------------------------------
package cpu_pkg;

   // Instruction class, instr[15:14]
   typedef enum logic [1:0] {
      OP1_LD  = 2'b00,
      OP1_ST  = 2'b01,
      OP1_IMM = 2'b10,
      OP1_ALU = 2'b11
   } op1_e;

   // Immediate / branch sub-op, instr[13:11] when op1 = OP1_IMM
   localparam logic [2:0] OP2_LI    = 3'b000;
   localparam logic [2:0] OP2_ADDI  = 3'b001;
   localparam logic [2:0] OP2_CMPI  = 3'b010;
   localparam logic [2:0] OP2_BCOND = 3'b100;
   localparam logic [2:0] OP2_B     = 3'b111;

   // ALU opcodes, instr[7:4] when op1 = OP1_ALU
   localparam logic [3:0] ALU_ADD  = 4'd0;
   localparam logic [3:0] ALU_SUB  = 4'd1;
   localparam logic [3:0] ALU_AND  = 4'd2;
   localparam logic [3:0] ALU_OR   = 4'd3;
   localparam logic [3:0] ALU_XOR  = 4'd4;
   localparam logic [3:0] ALU_CMP  = 4'd5;
   localparam logic [3:0] ALU_MOV  = 4'd6;
   localparam logic [3:0] ALU_RSV7 = 4'd7;
   localparam logic [3:0] ALU_SLL  = 4'd8;
   localparam logic [3:0] ALU_SLR  = 4'd9;
   localparam logic [3:0] ALU_SRL  = 4'd10;
   localparam logic [3:0] ALU_SRA  = 4'd11;
   localparam logic [3:0] ALU_IN   = 4'd12;
   localparam logic [3:0] ALU_OUT  = 4'd13;
   localparam logic [3:0] ALU_NOP  = 4'd14;
   localparam logic [3:0] ALU_HLT  = 4'd15;

   // Branch conditions, instr[10:8] for BCOND (evaluated inside the ALU)
   localparam logic [2:0] COND_BE  = 3'd0;
   localparam logic [2:0] COND_BLT = 3'd1;
   localparam logic [2:0] COND_BLE = 3'd2;
   localparam logic [2:0] COND_BNE = 3'd3;

   // Register write-back source
   typedef enum logic [1:0] {
      WB_ALU    = 2'd0,
      WB_LOAD   = 2'd1,
      WB_INPORT = 2'd2
   } wb_sel_e;

   // Sequencer state
   typedef enum logic [2:0] {
      ST_IDLE,
      ST_P1,
      ST_P2,
      ST_P3,
      ST_P4,
      ST_P5,
      ST_HALT
   } state_e;

   // Control bundle derived from the instruction register
   typedef struct packed {
      logic       flag_we;
      logic       rf_we;
      logic [2:0] waddr;
      wb_sel_e    wb_sel;
      logic       pc_sel;
      logic       is_ld;
      logic       is_st;
      logic       is_hlt;
   } decode_t;

endpackage

// File: rtl/alu_phase_controller_if.sv
// ---------------------------------------------------------------------------
// alu_phase_controller_if
// Instruction/data memory handshake between the phase controller (master)
// and the memory subsystem (slave).
//   imem_req   : fetch request (controller -> memory)
//   imem_ready : instruction word valid this cycle
//   instr_in   : 16-bit instruction word
//   dmem_re    : data read strobe, held until dmem_ready
//   dmem_we    : data write strobe, held until dmem_ready
//   dmem_ready : data access complete this cycle
// ---------------------------------------------------------------------------
interface alu_phase_controller_if;

   logic        imem_req;
   logic        imem_ready;
   logic [15:0] instr_in;
   logic        dmem_re;
   logic        dmem_we;
   logic        dmem_ready;

   modport master (
      output imem_req, dmem_re, dmem_we,
      input  imem_ready, instr_in, dmem_ready
   );

   modport slave (
      input  imem_req, dmem_re, dmem_we,
      output imem_ready, instr_in, dmem_ready
   );

endinterface

// File: rtl/alu_phase_controller_instr_decode.sv
// ---------------------------------------------------------------------------
// instr_decode
// Combinational decode of the instruction register into sequencer controls.
//   ir  : instruction register
//   dec : flag write enable, register write enable/address/source,
//         PC source select, load/store/halt markers
// ---------------------------------------------------------------------------
module instr_decode
   import cpu_pkg::*;
(
   input  logic [15:0] ir,
   output decode_t     dec
);

   op1_e       op1;
   logic [2:0] op2;
   logic [3:0] opc;

   assign op1 = op1_e'(ir[15:14]);
   assign op2 = ir[13:11];
   assign opc = ir[7:4];

   always_comb begin
      dec        = '0;
      dec.waddr  = ir[10:8];
      dec.wb_sel = WB_ALU;
      unique case (op1)
         OP1_LD: begin
            dec.is_ld  = 1'b1;
            dec.rf_we  = 1'b1;
            dec.waddr  = ir[13:11];
            dec.wb_sel = WB_LOAD;
         end
         OP1_ST: dec.is_st = 1'b1;
         OP1_IMM: begin
            unique case (op2)
               OP2_LI: dec.rf_we = 1'b1;
               OP2_ADDI, OP2_CMPI: begin
                  dec.rf_we   = 1'b1;
                  dec.flag_we = 1'b1;
               end
               // Taken/not-taken is resolved by the ALU; PC always loads its result
               OP2_BCOND, OP2_B: dec.pc_sel = 1'b1;
               default: ;
            endcase
         end
         OP1_ALU: begin
            unique case (opc)
               ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_MOV,
               ALU_SLL, ALU_SLR, ALU_SRL, ALU_SRA: begin
                  dec.rf_we   = 1'b1;
                  dec.flag_we = 1'b1;
               end
               ALU_CMP: dec.flag_we = 1'b1;
               ALU_IN: begin
                  dec.rf_we  = 1'b1;
                  dec.wb_sel = WB_INPORT;
               end
               ALU_HLT: dec.is_hlt = 1'b1;
               ALU_RSV7, ALU_OUT, ALU_NOP: ;
               default: ;
            endcase
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/alu_phase_controller.sv
// ---------------------------------------------------------------------------
// alu_phase_controller
// Five-phase multi-cycle sequencer (fetch, decode/read, execute, memory,
// writeback). Holds the instruction register, the architectural SZCV flag
// register and a stall watchdog that halts the core with fault=1 when a
// memory handshake waits STALL_LIMIT consecutive cycles.
//   clk, reset        : clock, asynchronous active-high reset
//   run               : start pulse, honoured only in IDLE
//   mem               : imem/dmem handshake (master modport)
//   alu_S/Z/C/V/HLT   : ALU flag and halt outputs
//   alu_op1..alu_cond : ALU control fields sliced from the IR
//   flags             : {S,Z,C,V} register feeding the ALU flag inputs
//   ra/rb/rf_*        : register-file read addresses and write port control
//   pc_we, pc_sel     : PC update strobe and source (0 PC+1, 1 ALU result)
//   phase             : one-hot P1..P5, zero in IDLE/HALT
//   halted, fault     : HALT state, halted by stall timeout
// ---------------------------------------------------------------------------
module alu_phase_controller
   import cpu_pkg::*;
#(
   parameter int         STALL_LIMIT = 255,
   parameter logic [3:0] RESET_FLAGS = 4'b0000
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          run,
   alu_phase_controller_if.master        mem,
   input  logic                          alu_S,
   input  logic                          alu_Z,
   input  logic                          alu_C,
   input  logic                          alu_V,
   input  logic                          alu_HLT,
   output logic [1:0]                    alu_op1,
   output logic [2:0]                    alu_op2,
   output logic [3:0]                    alu_opcode,
   output logic [3:0]                    alu_d,
   output logic [2:0]                    alu_cond,
   output logic [3:0]                    flags,
   output logic [2:0]                    ra_addr,
   output logic [2:0]                    rb_addr,
   output logic                          rf_we,
   output logic [2:0]                    rf_waddr,
   output logic [1:0]                    wb_sel,
   output logic                          pc_we,
   output logic                          pc_sel,
   output logic [4:0]                    phase,
   output logic                          halted,
   output logic                          fault
);

   localparam logic [7:0] LIMIT = 8'(STALL_LIMIT);

   state_e      state_q, state_d;
   logic [15:0] ir_q;
   logic [3:0]  flags_q;
   logic [7:0]  stall_cnt_q;
   logic        fault_q;
   decode_t     dec;
   logic        mem_op;
   logic        waiting;
   logic        timeout;
   logic        imem_req_c, dmem_re_c, dmem_we_c;

   instr_decode u_decode (
      .ir  (ir_q),
      .dec (dec)
   );

   assign mem_op  = dec.is_ld | dec.is_st;
   assign waiting = ((state_q == ST_P1) && !mem.imem_ready) ||
                    ((state_q == ST_P4) && mem_op && !mem.dmem_ready);
   // Timeout wins over a same-cycle ready so the halt is deterministic
   assign timeout = ((state_q == ST_P1) || (state_q == ST_P4)) && (stall_cnt_q == LIMIT);

   // State register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_q <= ST_IDLE;
      else       state_q <= state_d;
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE: if (run) state_d = ST_P1;
         ST_P1: begin
            if (timeout)             state_d = ST_HALT;
            else if (mem.imem_ready) state_d = ST_P2;
         end
         ST_P2: state_d = ST_P3;
         ST_P3: begin
            if (dec.is_hlt || alu_HLT) state_d = ST_HALT;
            else                       state_d = ST_P4;
         end
         ST_P4: begin
            if (timeout)                         state_d = ST_HALT;
            else if (!mem_op || mem.dmem_ready)  state_d = ST_P5;
         end
         ST_P5:   state_d = ST_P1;
         ST_HALT: state_d = ST_HALT;
         default: state_d = ST_IDLE;
      endcase
   end

   // Output logic: strobes come from state only, never straight from inputs
   always_comb begin
      phase      = '0;
      imem_req_c = 1'b0;
      dmem_re_c  = 1'b0;
      dmem_we_c  = 1'b0;
      rf_we      = 1'b0;
      pc_we      = 1'b0;
      pc_sel     = 1'b0;
      halted     = 1'b0;
      unique case (state_q)
         ST_P1: begin
            phase      = 5'b00001;
            imem_req_c = !timeout;
         end
         ST_P2: phase = 5'b00010;
         ST_P3: phase = 5'b00100;
         ST_P4: begin
            phase     = 5'b01000;
            dmem_re_c = dec.is_ld && !timeout;
            dmem_we_c = dec.is_st && !timeout;
         end
         ST_P5: begin
            phase  = 5'b10000;
            pc_we  = 1'b1;
            pc_sel = dec.pc_sel;
            rf_we  = dec.rf_we;
         end
         ST_HALT: halted = 1'b1;
         default: ;
      endcase
   end

   // IR, flag register, stall watchdog and fault latch
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ir_q        <= '0;
         flags_q     <= RESET_FLAGS;
         stall_cnt_q <= '0;
         fault_q     <= 1'b0;
      end else begin
         if ((state_q == ST_P1) && mem.imem_ready && !timeout)
            ir_q <= mem.instr_in;
         if ((state_q == ST_P3) && dec.flag_we)
            flags_q <= {alu_S, alu_Z, alu_C, alu_V};
         if (state_d != state_q)
            stall_cnt_q <= '0;
         else if (waiting)
            stall_cnt_q <= stall_cnt_q + 8'd1;
         if (timeout)
            fault_q <= 1'b1;
      end
   end

   assign mem.imem_req = imem_req_c;
   assign mem.dmem_re  = dmem_re_c;
   assign mem.dmem_we  = dmem_we_c;

   assign alu_op1    = ir_q[15:14];
   assign alu_op2    = ir_q[13:11];
   assign alu_cond   = ir_q[10:8];
   assign alu_opcode = ir_q[7:4];
   assign alu_d      = ir_q[3:0];
   assign ra_addr    = ir_q[13:11];
   assign rb_addr    = ir_q[10:8];
   assign rf_waddr   = dec.waddr;
   assign wb_sel     = dec.wb_sel;
   assign flags      = flags_q;
   assign fault      = fault_q;

endmodule

// File: tb/tb_alu_phase_controller.sv
// Scoreboarded bench for alu_phase_controller: the stimulus process plays the
// memory side and pushes one expected completion per instruction; the monitor
// pops on every pc_we pulse or entry into HALT.
module tb_alu_phase_controller;

   localparam int         LIMIT     = 4;
   localparam logic [3:0] RST_FLAGS = 4'b1010;

   logic        clk = 1'b0;
   logic        reset, run;
   logic        alu_S, alu_Z, alu_C, alu_V, alu_HLT;
   logic [1:0]  alu_op1;
   logic [2:0]  alu_op2, alu_cond;
   logic [3:0]  alu_opcode, alu_d, flags;
   logic [2:0]  ra_addr, rb_addr, rf_waddr;
   logic        rf_we, pc_we, pc_sel, halted, fault;
   logic [1:0]  wb_sel;
   logic [4:0]  phase;

   alu_phase_controller_if mif();

   alu_phase_controller #(.STALL_LIMIT(LIMIT), .RESET_FLAGS(RST_FLAGS)) dut (
      .clk(clk), .reset(reset), .run(run), .mem(mif),
      .alu_S(alu_S), .alu_Z(alu_Z), .alu_C(alu_C), .alu_V(alu_V), .alu_HLT(alu_HLT),
      .alu_op1(alu_op1), .alu_op2(alu_op2), .alu_opcode(alu_opcode), .alu_d(alu_d),
      .alu_cond(alu_cond), .flags(flags), .ra_addr(ra_addr), .rb_addr(rb_addr),
      .rf_we(rf_we), .rf_waddr(rf_waddr), .wb_sel(wb_sel), .pc_we(pc_we), .pc_sel(pc_sel),
      .phase(phase), .halted(halted), .fault(fault)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [15:0] ins;
      bit          halt;
      bit          fault;
      bit          rf_we;
      logic [2:0]  waddr;
      logic [1:0]  wb;
      bit          pc_sel;
      logic [3:0]  flags;
      int          cycles;
      int          ireq;
      int          re;
      int          we;
   } exp_t;

   exp_t        sbq[$];
   int          total = 0;
   int          bad   = 0;
   logic [3:0]  mflags;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
      end
   endtask

   // Reference model: expected completion from the instruction-set rules
   task automatic predict(input logic [15:0] ins, input logic [3:0] af, input bit ahlt,
                          input int iw, input int dw, output exp_t e);
      int op1, op2, opc;
      bit is_alu, is_imm;
      op1 = int'(ins[15:14]);
      op2 = int'(ins[13:11]);
      opc = int'(ins[7:4]);
      is_alu = (op1 == 3);
      is_imm = (op1 == 2);
      e = '{default: 0};
      e.ins = ins;
      if ((is_alu && (opc inside {[0:6], [8:11]})) || (is_imm && (op2 inside {1, 2})))
         mflags = af;
      e.flags = mflags;
      e.ireq  = iw + 1;
      if ((is_alu && opc == 15) || ahlt) begin
         e.halt   = 1;
         e.cycles = 3 + iw;
         return;
      end
      e.cycles = 5 + iw + ((op1 < 2) ? dw : 0);
      e.re     = (op1 == 0) ? dw + 1 : 0;
      e.we     = (op1 == 1) ? dw + 1 : 0;
      e.pc_sel = is_imm && (op2 inside {4, 7});
      if (op1 == 0) begin
         e.rf_we = 1; e.waddr = ins[13:11]; e.wb = 2'd1;
      end else if (is_alu && !(opc inside {5, 7, 13, 14, 15})) begin
         e.rf_we = 1; e.waddr = ins[10:8]; e.wb = (opc == 12) ? 2'd2 : 2'd0;
      end else if (is_imm && op2 <= 2) begin
         e.rf_we = 1; e.waddr = ins[10:8]; e.wb = 2'd0;
      end
   endtask

   task automatic pulse_run();
      run = 1'b1;
      @(negedge clk);
      run = 1'b0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1;
      sbq.delete();
      mflags = RST_FLAGS;
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic wait_halted(input string name, input int budget);
      int n = 0;
      while (!halted && n < budget) begin
         @(negedge clk);
         n++;
      end
      if (!halted) begin
         total++; bad++;
         $display("FAIL %s: halted still 0 after %0d cycles, required 1", name, budget);
      end
   endtask

   // Act as the memory for one instruction and push its expected completion
   task automatic issue(input logic [15:0] ins, input logic [3:0] af, input bit ahlt,
                        input int iw, input int dw);
      exp_t e;
      int   n = 0;
      while (!mif.imem_req && n < 40) begin
         @(negedge clk);
         n++;
      end
      if (!mif.imem_req) begin
         total++; bad++;
         $display("FAIL fetch_wait: imem_req still 0 after 40 cycles, required 1");
         return;
      end
      predict(ins, af, ahlt, iw, dw, e);
      sbq.push_back(e);
      mif.instr_in = ins;
      {alu_S, alu_Z, alu_C, alu_V} = af;
      alu_HLT = ahlt;
      mif.imem_ready = 1'b0;
      repeat (iw) @(negedge clk);
      mif.imem_ready = 1'b1;
      @(negedge clk);
      mif.imem_ready = 1'b0;
      if (ins[15:14] < 2'd2 && !ahlt) begin
         n = 0;
         while (!(mif.dmem_re || mif.dmem_we) && n < 20) begin
            @(negedge clk);
            n++;
         end
         if (!(mif.dmem_re || mif.dmem_we)) begin
            total++; bad++;
            $display("FAIL dmem_wait: no dmem strobe after 20 cycles, required one");
            return;
         end
         mif.dmem_ready = 1'b0;
         repeat (dw) @(negedge clk);
         mif.dmem_ready = 1'b1;
         @(negedge clk);
         mif.dmem_ready = 1'b0;
      end
   endtask

   // Monitor: pops an expectation at each instruction completion or halt entry
   initial begin : monitor
      int   cyc = 0, ireq = 0, re = 0, we = 0;
      bit   hseen = 0;
      exp_t e;
      forever begin
         @(negedge clk);
         if (reset) begin
            cyc = 0; ireq = 0; re = 0; we = 0; hseen = 0;
         end else begin
            if (phase != 5'd0) cyc++;
            if (mif.imem_req)  ireq++;
            if (mif.dmem_re)   re++;
            if (mif.dmem_we)   we++;
            if (pc_we || (halted && !hseen)) begin
               if (sbq.size() == 0) begin
                  total++; bad++;
                  $display("FAIL unexpected_event: got pc_we=%0b halted=%0b, required no event", pc_we, halted);
               end else begin
                  e = sbq.pop_front();
                  check("halted", {31'd0, halted}, {31'd0, e.halt});
                  check("fault", {31'd0, fault}, {31'd0, e.fault});
                  check("cycles", cyc, e.cycles);
                  check("imem_req_cycles", ireq, e.ireq);
                  check("flags", {28'd0, flags}, {28'd0, e.flags});
                  check("alu_fields", {16'd0, alu_op1, alu_op2, alu_cond, alu_opcode, alu_d}, {16'd0, e.ins});
                  check("rd_addrs", {26'd0, ra_addr, rb_addr}, {26'd0, e.ins[13:8]});
                  if (e.halt) begin
                     check("halt_strobes", {27'd0, pc_we, rf_we, mif.imem_req, mif.dmem_re, mif.dmem_we}, 32'd0);
                  end else begin
                     check("dmem_re_cycles", re, e.re);
                     check("dmem_we_cycles", we, e.we);
                     check("rf_we", {31'd0, rf_we}, {31'd0, e.rf_we});
                     check("pc_sel", {31'd0, pc_sel}, {31'd0, e.pc_sel});
                     if (e.rf_we) begin
                        check("rf_waddr", {29'd0, rf_waddr}, {29'd0, e.waddr});
                        check("wb_sel", {30'd0, wb_sel}, {30'd0, e.wb});
                     end
                  end
               end
               hseen = halted;
               cyc = 0; ireq = 0; re = 0; we = 0;
            end
         end
      end
   end

   initial begin : stim
      logic [15:0] ins;
      int          n;
      reset = 1'b1; run = 1'b0; alu_HLT = 1'b0;
      {alu_S, alu_Z, alu_C, alu_V} = 4'b0000;
      mif.imem_ready = 1'b0; mif.dmem_ready = 1'b0; mif.instr_in = 16'h0000;
      mflags = RST_FLAGS;
      repeat (2) @(negedge clk);
      check("reset_phase", {27'd0, phase}, 32'd0);
      check("reset_flags", {28'd0, flags}, {28'd0, RST_FLAGS});
      check("reset_status", {30'd0, halted, fault}, 32'd0);
      check("reset_strobes", {27'd0, pc_we, rf_we, mif.imem_req, mif.dmem_re, mif.dmem_we}, 32'd0);
      reset = 1'b0;
      repeat (3) @(negedge clk);
      check("idle_hold", {26'd0, phase, mif.imem_req}, 32'd0);

      pulse_run();
      issue(16'hC100, 4'b0100, 1'b0, 0, 0);   // ADD
      issue(16'hC250, 4'b1000, 1'b0, 1, 0);   // CMP
      issue(16'hC360, 4'b0100, 1'b0, 0, 0);   // MOV
      issue(16'hC370, 4'b1111, 1'b0, 2, 0);   // opcode 7
      issue(16'h1800, 4'b0011, 1'b0, 0, 3);   // LD with 3 wait states
      issue(16'h4A00, 4'b0011, 1'b0, 1, 2);   // ST
      issue(16'hB805, 4'b0011, 1'b0, 0, 0);   // B
      issue(16'hC4C0, 4'b1100, 1'b0, 3, 0);   // IN, fetch waits just under the limit
      issue(16'hC5D0, 4'b1100, 1'b0, 0, 0);   // OUT
      issue(16'h8A00, 4'b0110, 1'b0, 0, 0);   // ADDI
      for (int i = 0; i < 80; i++) begin
         ins = 16'($urandom);
         if (ins[15:14] == 2'b11 && ins[7:4] == 4'd15) ins[7:4] = 4'd14;
         issue(ins, 4'($urandom), 1'b0, $urandom_range(0, 3), $urandom_range(0, 3));
      end

      issue(16'hC0F0, 4'b0101, 1'b0, 1, 0);   // HLT
      wait_halted("hlt_wait", 20);
      pulse_run();
      for (int i = 0; i < 4; i++) begin
         check("halt_sticky", {25'd0, halted, phase, pc_we}, {25'd0, 1'b1, 5'd0, 1'b0});
         @(negedge clk);
      end
      #2 reset = 1'b1;
      sbq.delete();
      mflags = RST_FLAGS;
      #1 check("async_reset_state", {25'd0, flags, halted, fault, phase == 5'd0}, {25'd0, RST_FLAGS, 3'b001});
      @(negedge clk);
      reset = 1'b0;

      @(negedge clk);
      pulse_run();
      issue(16'hC100, 4'b0111, 1'b1, 1, 0);   // ALU raises HLT
      wait_halted("alu_hlt_wait", 20);
      do_reset();

      // Fetch that never completes must trip the watchdog
      alu_HLT = 1'b0;
      begin
         exp_t e;
         e = '{default: 0};
         e.halt = 1; e.fault = 1; e.flags = mflags;
         e.cycles = LIMIT + 1; e.ireq = LIMIT;
         sbq.push_back(e);
      end
      pulse_run();
      wait_halted("timeout_wait", 30);
      check("timeout_imem_req", {31'd0, mif.imem_req}, 32'd0);
      check("timeout_fault", {31'd0, fault}, 32'd1);
      do_reset();

      // Reset in the middle of a store
      pulse_run();
      mif.instr_in = 16'h4100;
      mif.imem_ready = 1'b1;
      @(negedge clk);
      mif.imem_ready = 1'b0;
      n = 0;
      while (!mif.dmem_we && n < 20) begin
         @(negedge clk);
         n++;
      end
      check("st_strobe_up", {31'd0, mif.dmem_we}, 32'd1);
      #2 reset = 1'b1;
      #1 check("st_drop_async", {31'd0, mif.dmem_we}, 32'd0);
      @(negedge clk);
      reset = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check("st_not_reissued", {26'd0, mif.dmem_we, phase}, 32'd0);
      end

      check("scoreboard_empty", sbq.size(), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
